// File: rtl/bmp_pkg.sv
// Shared constants, FSM state type and BMP geometry helpers for the BMP stream writer.
package bmp_pkg;
  localparam logic [31:0] HDR_BYTES = 32'd54;
  localparam logic [31:0] DIB_SIZE  = 32'd40;
  localparam logic [31:0] BPP       = 32'd24;
  localparam logic [31:0] PPM       = 32'd2835;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX,
    ST_PAD,
    ST_DONE
  } state_e;

  // Zero bytes that round a 3*w-byte row up to a multiple of four.
  function automatic logic [31:0] row_pad(input logic [31:0] w);
    logic [31:0] rowb;
    logic [1:0]  pad;
    rowb = w * 32'd3;
    pad  = 2'd0 - rowb[1:0];
    return {30'd0, pad};
  endfunction

  function automatic logic [31:0] stride(input logic [31:0] w);
    return (w * 32'd3) + row_pad(w);
  endfunction

  function automatic logic [31:0] file_size(input logic [31:0] w, input logic [31:0] h);
    return HDR_BYTES + (stride(w) * h);
  endfunction
endpackage

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP/DIB header lookup: byte index plus image geometry to header byte.
module bmp_header_rom
  import bmp_pkg::*;
(
  input  logic [5:0]  index,
  input  logic [31:0] width,
  input  logic [31:0] height,
  output logic [7:0]  data
);

  logic [5:0]  rel;
  logic [31:0] word;
  logic [31:0] img_size;

  // Past the 'BM' magic every field sits in a 4-byte lane grid starting at byte 2;
  // the two 16-bit fields (planes, bpp) share one lane word.
  assign rel      = index - 6'd2;
  assign img_size = stride(width) * height;

  always_comb begin
    word = 32'd0;
    case (rel[5:2])
      4'd0:        word = file_size(width, height);
      4'd1:        word = 32'd0;
      4'd2:        word = HDR_BYTES;
      4'd3:        word = DIB_SIZE;
      4'd4:        word = width;
      4'd5:        word = 32'd0 - height;
      4'd6:        word = {BPP[15:0], 16'd1};
      4'd8:        word = img_size;
      4'd9, 4'd10: word = PPM;
      default:     word = 32'd0;
    endcase

    data = word[{rel[1:0], 3'b000} +: 8];
    if (index == 6'd0) begin
      data = 8'h42;
    end else if (index == 6'd1) begin
      data = 8'h4D;
    end
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Serializes a raster RGB pixel stream into a top-down 24-bit BMP byte stream with row padding.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_last,
  output logic       busy,
  output logic       done
);

  localparam int unsigned      COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned      ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [31:0]      PAD_L    = row_pad(32'(WIDTH));
  localparam logic [1:0]       PAD_N    = PAD_L[1:0];
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  // Handshakes: a byte moves on a rising edge with byte_valid & byte_ready, a pixel with
  // pix_valid & pix_ready. byte_valid never drops and byte_data/byte_last never change
  // until the byte is taken, since all of them decode only registered state.
  state_e           state_q, state_d;
  logic [5:0]       hidx_q, hidx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       comp_q, comp_d;
  logic [1:0]       pad_q, pad_d;
  logic             held_q, held_d;
  logic [23:0]      pix_q, pix_d;

  logic [7:0] hdr_byte;
  logic       last_col;
  logic       last_row;
  logic       byte_hs;
  logic       pix_hs;

  bmp_header_rom u_header_rom (
    .index  (hidx_q),
    .width  (32'(WIDTH)),
    .height (32'(HEIGHT)),
    .data   (hdr_byte)
  );

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);
  assign byte_hs  = byte_valid & byte_ready;
  assign pix_hs   = pix_valid & pix_ready;

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    byte_last  = 1'b0;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_HDR: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        byte_data  = hdr_byte;
      end
      ST_PIX: begin
        busy       = 1'b1;
        pix_ready  = !held_q;
        byte_valid = held_q;
        if (held_q) begin
          case (comp_q)
            2'd0:    byte_data = pix_q[23:16];
            2'd1:    byte_data = pix_q[15:8];
            default: byte_data = pix_q[7:0];
          endcase
        end
        byte_last = held_q && (comp_q == 2'd2) && last_col && last_row && (PAD_N == 2'd0);
      end
      ST_PAD: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        byte_last  = last_row && (pad_q == PAD_N - 2'd1);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hidx_d  = hidx_q;
    col_d   = col_q;
    row_d   = row_q;
    comp_d  = comp_q;
    pad_d   = pad_q;
    held_d  = held_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          hidx_d  = 6'd0;
        end
      end
      ST_HDR: begin
        if (byte_hs) begin
          hidx_d = hidx_q + 6'd1;
          if (hidx_q == 6'(HDR_BYTES - 32'd1)) begin
            state_d = ST_PIX;
            col_d   = '0;
            row_d   = '0;
            comp_d  = 2'd0;
            held_d  = 1'b0;
          end
        end
      end
      ST_PIX: begin
        // Pixel and byte handshakes are mutually exclusive: pix_ready is !held, byte_valid is held.
        if (pix_hs) begin
          pix_d  = {pix_b, pix_g, pix_r};
          held_d = 1'b1;
          comp_d = 2'd0;
        end else if (byte_hs) begin
          if (comp_q == 2'd2) begin
            held_d = 1'b0;
            comp_d = 2'd0;
            if (last_col) begin
              col_d = '0;
              if (PAD_N != 2'd0) begin
                state_d = ST_PAD;
                pad_d   = 2'd0;
              end else if (last_row) begin
                state_d = ST_DONE;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            comp_d = comp_q + 2'd1;
          end
        end
      end
      ST_PAD: begin
        if (byte_hs) begin
          if (pad_q == PAD_N - 2'd1) begin
            pad_d = 2'd0;
            if (last_row) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = ST_PIX;
            end
          end else begin
            pad_d = pad_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hidx_q  <= 6'd0;
      col_q   <= '0;
      row_q   <= '0;
      comp_q  <= 2'd0;
      pad_q   <= 2'd0;
      held_q  <= 1'b0;
      pix_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      hidx_q  <= hidx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      comp_q  <= comp_d;
      pad_q   <= pad_d;
      held_q  <= held_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: four geometries (768x512, 2x2, 1x1, 4x2) share one stimulus bus picked by sel.
`timescale 1ns/1ps
module tb_bmp_stream_writer;

  localparam int N_DUT = 4;

  function automatic int unsigned cfg_w(input int k);
    case (k)
      0:       return 768;
      1:       return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned cfg_h(input int k);
    case (k)
      0:       return 512;
      1:       return 2;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    int         idx;
    logic [7:0] val;
  } bvec_t;

  // ---------------- clock / reset / bus ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_r, pix_g, pix_b;
  logic       byte_ready;
  logic [1:0] sel;

  logic [N_DUT-1:0]      pr_v, bv_v, bl_v, busy_v, done_v;
  logic [N_DUT-1:0][7:0] bd_v;

  logic       cur_pready, cur_valid, cur_last, cur_busy, cur_done;
  logic [7:0] cur_data;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N_DUT; k++) begin : g_dut
    bmp_stream_writer #(
      .WIDTH  (cfg_w(k)),
      .HEIGHT (cfg_h(k))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start && (sel == 2'(k))),
      .pix_valid  (pix_valid && (sel == 2'(k))),
      .pix_ready  (pr_v[k]),
      .pix_r      (pix_r),
      .pix_g      (pix_g),
      .pix_b      (pix_b),
      .byte_valid (bv_v[k]),
      .byte_ready (byte_ready && (sel == 2'(k))),
      .byte_data  (bd_v[k]),
      .byte_last  (bl_v[k]),
      .busy       (busy_v[k]),
      .done       (done_v[k])
    );
  end

  assign cur_pready = pr_v[sel];
  assign cur_valid  = bv_v[sel];
  assign cur_data   = bd_v[sel];
  assign cur_last   = bl_v[sel];
  assign cur_busy   = busy_v[sel];
  assign cur_done   = done_v[sel];

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [7:0] got[128];
  logic [8:0] mon_e;
  int         n_rx, last_cnt, done_cnt;
  int         checks = 0;
  int         errors = 0;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  bit         run_end, abort_px;
  logic [7:0] px_r[8], px_g[8], px_b[8];

  bvec_t t768[20];
  bvec_t t22[20];
  bvec_t t11[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected {last,data} per accepted byte; checks hold-while-stalled and done/busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!cur_valid || cur_data !== prev_data || cur_last !== prev_last) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                   cur_valid, cur_data, cur_last, prev_data, prev_last);
        end
      end
      if (cur_valid && byte_ready) begin
        if (n_rx < 128) got[n_rx] = cur_data;
        if (cur_last) last_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte[%0d]: got %02h with nothing expected", n_rx, cur_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({cur_last, cur_data} !== mon_e) begin
            errors++;
            $display("FAIL stream_byte[%0d]: got last=%0b data=%02h, required last=%0b data=%02h",
                     n_rx, cur_last, cur_data, mon_e[8], mon_e[7:0]);
          end
        end
        n_rx++;
      end
      if (cur_done) begin
        done_cnt++;
        check("busy_low_at_done", {31'd0, cur_busy}, 32'd0);
      end
      prev_stall = cur_valid && !byte_ready;
      prev_data  = cur_data;
      prev_last  = cur_last;
    end
  end

  // ---------------- reference model ----------------
  task automatic push_le(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 8'(v >> (8 * i))});
  endtask

  task automatic build_expected(input int w, input int h, input bit with_pix, output int fsize);
    int rowb, pad, img;
    logic [8:0] e;
    rowb  = w * 3;
    pad   = (4 - rowb % 4) % 4;
    img   = (rowb + pad) * h;
    fsize = 54 + img;
    exp_q.delete();
    push_le(32'h4D42, 2);
    push_le(32'(fsize), 4);
    push_le(32'd0, 4);
    push_le(32'd54, 4);
    push_le(32'd40, 4);
    push_le(32'(w), 4);
    push_le(32'(-h), 4);
    push_le(32'd1, 2);
    push_le(32'd24, 2);
    push_le(32'd0, 4);
    push_le(32'(img), 4);
    push_le(32'd2835, 4);
    push_le(32'd2835, 4);
    push_le(32'd0, 4);
    push_le(32'd0, 4);
    if (with_pix) begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          exp_q.push_back({1'b0, px_b[r * w + c]});
          exp_q.push_back({1'b0, px_g[r * w + c]});
          exp_q.push_back({1'b0, px_r[r * w + c]});
        end
        for (int p = 0; p < pad; p++) exp_q.push_back(9'h000);
      end
      e = exp_q.pop_back();
      exp_q.push_back(e | 9'h100);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit gaps);
    bit accepted;
    int cyc;
    for (int i = 0; i < n && !abort_px; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      pix_valid = 1'b1;
      pix_r     = px_r[i];
      pix_g     = px_g[i];
      pix_b     = px_b[i];
      accepted  = 1'b0;
      cyc       = 0;
      while (!accepted && !abort_px && !run_end && cyc < 2000) begin
        @(negedge clk);
        if (cur_pready && rst_n) accepted = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      pix_valid = 1'b0;
      if (!abort_px) check($sformatf("pixel_accepted[%0d]", i), {31'd0, accepted}, 32'd1);
    end
  endtask

  task automatic drive_ready(input bit rnd);
    while (!run_end) begin
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    run_end = 1'b1;
  endtask

  task automatic restart_pulses();
    int cyc;
    cyc = 0;
    while (n_rx < 10 && !run_end && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    pulse_start();
    cyc = 0;
    while (n_rx < 58 && !run_end && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!run_end) pulse_start();
  endtask

  task automatic run_image(input logic [1:0] k, input bit rnd, input bit gaps, input bit repulse);
    int w, h, fsize;
    w = int'(cfg_w(k));
    h = int'(cfg_h(k));
    sel = k;
    build_expected(w, h, 1'b1, fsize);
    n_rx = 0; last_cnt = 0; done_cnt = 0;
    run_end = 1'b0; abort_px = 1'b0;
    pulse_start();
    check("busy_after_start", {31'd0, cur_busy}, 32'd1);
    fork
      drive_pixels(w * h, gaps);
      drive_ready(rnd);
      wait_done(4000);
      begin
        if (repulse) restart_pulses();
      end
    join
    check("bytes_total", 32'(n_rx), 32'(fsize));
    check("last_count", 32'(last_cnt), 32'd1);
    check("done_count", 32'(done_cnt), 32'd1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int fsize, cyc;

    t768 = '{'{0, 8'h42}, '{1, 8'h4D},
             '{2, 8'h36}, '{3, 8'h00}, '{4, 8'h12}, '{5, 8'h00},
             '{10, 8'h36}, '{28, 8'h18},
             '{18, 8'h00}, '{19, 8'h03}, '{20, 8'h00}, '{21, 8'h00},
             '{22, 8'h00}, '{23, 8'hFE}, '{24, 8'hFF}, '{25, 8'hFF},
             '{34, 8'h00}, '{35, 8'h00}, '{36, 8'h12}, '{37, 8'h00}};
    t22  = '{'{2, 8'h46}, '{3, 8'h00}, '{4, 8'h00}, '{5, 8'h00},
             '{54, 8'h03}, '{55, 8'h02}, '{56, 8'h01}, '{57, 8'h06},
             '{58, 8'h05}, '{59, 8'h04}, '{60, 8'h00}, '{61, 8'h00},
             '{62, 8'h09}, '{63, 8'h08}, '{64, 8'h07}, '{65, 8'h0C},
             '{66, 8'h0B}, '{67, 8'h0A}, '{68, 8'h00}, '{69, 8'h00}};
    t11  = '{'{2, 8'h3A}, '{3, 8'h00}, '{4, 8'h00}, '{5, 8'h00},
             '{54, 8'hCC}, '{55, 8'hBB}, '{56, 8'hAA}, '{57, 8'h00}};

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; byte_ready = 1'b1; sel = 2'd0;
    pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd0;
    n_rx = 0; last_cnt = 0; done_cnt = 0; run_end = 1'b1; abort_px = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("reset_outputs", {19'd0, cur_valid, cur_data, cur_last, cur_busy, cur_done, cur_pready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 768x512: full header through the scoreboard, spot fields from the table, then abort by reset.
    sel = 2'd0;
    build_expected(768, 512, 1'b0, fsize);
    n_rx = 0; last_cnt = 0; done_cnt = 0;
    pulse_start();
    check("busy_after_start_768", {31'd0, cur_busy}, 32'd1);
    cyc = 0;
    while (n_rx < 54 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hdr768_count", 32'(n_rx), 32'd54);
    for (int i = 0; i < 20; i++)
      check($sformatf("hdr768[%0d]", t768[i].idx), {24'd0, got[t768[i].idx]}, {24'd0, t768[i].val});
    check("pix_ready_after_hdr", {31'd0, cur_pready}, 32'd1);
    check("byte_valid_idle_pix", {31'd0, cur_valid}, 32'd0);
    check("exp_q_drained_768", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0; #1;
    check("reset_abort_768", {19'd0, cur_valid, cur_data, cur_last, cur_busy, cur_done, cur_pready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2 reference image from the pixel table.
    for (int i = 0; i < 4; i++) begin
      px_r[i] = 8'(3 * i + 1);
      px_g[i] = 8'(3 * i + 2);
      px_b[i] = 8'(3 * i + 3);
    end
    run_image(2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      check($sformatf("img22[%0d]", t22[i].idx), {24'd0, got[t22[i].idx]}, {24'd0, t22[i].val});

    // Same image with sink back-pressure and source gaps.
    run_image(2'd1, 1'b1, 1'b1, 1'b0);

    // start re-pulsed mid-header and mid-pixels must be ignored.
    run_image(2'd1, 1'b0, 1'b0, 1'b1);

    // Reset while emitting row 1, then a fresh complete image.
    sel = 2'd1;
    build_expected(2, 2, 1'b1, fsize);
    n_rx = 0; last_cnt = 0; done_cnt = 0; run_end = 1'b0; abort_px = 1'b0;
    pulse_start();
    fork
      drive_pixels(4, 1'b0);
      drive_ready(1'b0);
      begin : reset_in_pix
        int rc;
        rc = 0;
        while (n_rx < 64 && rc < 1000) begin
          @(posedge clk); #1;
          rc++;
        end
        check("reached_row1", {31'd0, (n_rx >= 64)}, 32'd1);
        rst_n = 1'b0; #1;
        check("reset_in_pix_outputs",
              {19'd0, cur_valid, cur_data, cur_last, cur_busy, cur_done, cur_pready}, 32'd0);
        abort_px = 1'b1;
        run_end  = 1'b1;
      end
    join
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_image(2'd1, 1'b0, 1'b0, 1'b0);
    check("fresh_hdr[0]", {24'd0, got[0]}, 32'h42);
    check("fresh_hdr[1]", {24'd0, got[1]}, 32'h4D);

    // 1x1 image: one pixel plus one pad byte.
    px_r[0] = 8'hAA; px_g[0] = 8'hBB; px_b[0] = 8'hCC;
    run_image(2'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("img11[%0d]", t11[i].idx), {24'd0, got[t11[i].idx]}, {24'd0, t11[i].val});

    // 4x2 image: no row padding, byte_last lands on the final R byte.
    for (int i = 0; i < 8; i++) begin
      px_r[i] = 8'($urandom_range(0, 255));
      px_g[i] = 8'($urandom_range(0, 255));
      px_b[i] = 8'($urandom_range(0, 255));
    end
    run_image(2'd3, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
